// File: rtl/ras_ckpt_pkg.sv
// Shared definitions for the checkpointed return-address stack.
package ras_ckpt_pkg;

  // Stack operation selected for the current cycle once flush/restore priority is applied.
  typedef enum logic [2:0] {
    OP_HOLD,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_UNDERFLOW
  } ras_op_e;

  // Index width that stays legal when only one checkpoint slot exists.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ras_ckpt.sv
// Return-address stack with wrap-on-overflow, push/pop replace and
// single-cycle checkpoint restore of the top entry, tp and cnt.
module ras_ckpt
  import ras_ckpt_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned VLEN    = 32,
  parameter int unsigned NR_CKPT = 4,
  localparam int unsigned TPW    = $clog2(DEPTH),
  localparam int unsigned CW     = $clog2(DEPTH + 1),
  localparam int unsigned IW     = idx_width(NR_CKPT)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_bp_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [VLEN-1:0] data_i,
  output logic [VLEN:0]   data_o,
  input  logic            ckpt_save_i,
  input  logic [IW-1:0]   ckpt_idx_i,
  input  logic            restore_i,
  input  logic [IW-1:0]   restore_idx_i,
  output logic            overflow_o,
  output logic            underflow_o
);

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] ra;
  } ras_t;

  typedef struct packed {
    logic [TPW-1:0]  tp;
    logic [CW-1:0]   cnt;
    logic [VLEN-1:0] top;
  } ras_ckpt_t;

  logic [VLEN-1:0]    stack_q [DEPTH];
  logic [TPW-1:0]     tp_q;
  logic [CW-1:0]      cnt_q;
  ras_ckpt_t          ckpt_q [NR_CKPT];
  logic [NR_CKPT-1:0] ckpt_valid_q;
  logic               overflow_q;
  logic               underflow_q;

  logic      restore_hit;
  logic      flush_eff;
  logic      full;
  logic      empty;
  logic [TPW-1:0] tp_inc;
  logic [TPW-1:0] tp_dec;
  ras_op_e   op;
  ras_t      pred;
  ras_ckpt_t restore_ckpt;

  assign full         = (cnt_q == CW'(DEPTH));
  assign empty        = (cnt_q == '0);
  assign tp_inc       = (tp_q == TPW'(DEPTH - 1)) ? '0 : tp_q + TPW'(1);
  assign tp_dec       = (tp_q == '0) ? TPW'(DEPTH - 1) : tp_q - TPW'(1);
  assign restore_ckpt = ckpt_q[restore_idx_i];
  assign restore_hit  = restore_i && ckpt_valid_q[restore_idx_i];
  // Restoring from a slot that was never saved (or was flushed) leaves nothing to trust.
  assign flush_eff    = flush_bp_i || (restore_i && !ckpt_valid_q[restore_idx_i]);

  always_comb begin
    op = OP_HOLD;
    if (!flush_eff && !restore_i) begin
      unique case ({push_i, pop_i})
        2'b10:   op = OP_PUSH;
        2'b01:   op = empty ? OP_UNDERFLOW : OP_POP;
        2'b11:   op = empty ? OP_PUSH : OP_REPLACE;
        default: op = OP_HOLD;
      endcase
    end
  end

  always_comb begin
    pred.valid = !empty;
    pred.ra    = empty ? '0 : stack_q[tp_q];
  end

  assign data_o      = pred;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tp_q         <= '0;
      cnt_q        <= '0;
      ckpt_valid_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      for (int i = 0; i < NR_CKPT; i++) ckpt_q[i] <= '0;
    end else begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      if (flush_eff) begin
        tp_q         <= '0;
        cnt_q        <= '0;
        ckpt_valid_q <= '0;
      end else if (restore_hit) begin
        tp_q                      <= restore_ckpt.tp;
        cnt_q                     <= restore_ckpt.cnt;
        stack_q[restore_ckpt.tp]  <= restore_ckpt.top;
      end else begin
        unique case (op)
          OP_PUSH: begin
            tp_q            <= tp_inc;
            stack_q[tp_inc] <= data_i;
            // A full stack wraps onto its oldest entry instead of growing.
            if (full) overflow_q <= 1'b1;
            else      cnt_q      <= cnt_q + CW'(1);
          end
          OP_POP: begin
            tp_q  <= tp_dec;
            cnt_q <= cnt_q - CW'(1);
          end
          OP_REPLACE:   stack_q[tp_q] <= data_i;
          OP_UNDERFLOW: underflow_q   <= 1'b1;
          default: ;
        endcase
      end
      // Save snapshots pre-update state; a same-slot restore above already read the old copy.
      if (ckpt_save_i && !flush_eff) begin
        ckpt_valid_q[ckpt_idx_i] <= 1'b1;
        ckpt_q[ckpt_idx_i]       <= '{tp: tp_q, cnt: cnt_q, top: stack_q[tp_q]};
      end
    end
  end

endmodule
